spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
// - SPI mode-0 initiator that drives the chip's SPI register-write peripheral; it generates sclk, cs (active-low) and copi.
// - Takes one register-write request per valid/ready handshake and serialises it as one 16-bit frame.
// - Used as the on-chip / bench-side master that writes the en_out, en_pwm and pwm_duty_cycle registers.
// - Frame layout: bit0 = write flag, bits[7:1] = address, bits[15:8] = data.
// - Frame is transmitted bit0 first (LSB-first), one bit per sclk rising edge.
// PARAMETERS
// - CLK_DIV   4  clk cycles per sclk half-period; min 2 (peripheral samples sclk through a 2-flop sync)
// - CS_SETUP  4  clk cycles from cs fall to first sclk rise; min 2
// - CS_GAP    8  min clk cycles cs stays high between frames; min 2
// PORTS
// - clk        in   1  system clock
// - rst        in   1  synchronous, active-high reset
// - req_valid  in   1  request present
// - req_ready  out  1  controller idle, can accept a request
// - req_wr     in   1  value sent as frame bit0 (1 = write; 0 = frame ignored by peripheral)
// - req_addr   in   7  register address, frame bits[7:1]
// - req_data   in   8  register data, frame bits[15:8]
// - busy       out  1  frame in flight (cs low or inter-frame gap running)
// - done       out  1  one-cycle pulse in the cycle cs returns high
// - sclk       out  1  SPI clock; idles low
// - cs         out  1  chip select, active-low; idles high
// - copi       out  1  serial data; changes only while sclk is low
// BEHAVIOUR
// - Reset values: cs=1, sclk=0, copi=0, busy=0, done=0, req_ready=1. FSM state = IDLE; all counters = 0.
// - All outputs are registered; no combinational path from input to output except req_ready = (state==IDLE).
// - Handshake:
//   - A request is accepted on the clk edge where req_valid && req_ready.
//   - {req_data, req_addr, req_wr} is latched into a 16-bit shift register on acceptance.
//   - Inputs are ignored while req_ready=0.
// - FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// - IDLE
//   - On accept: next cycle cs=0, copi=frame[0], busy=1. Enter SETUP.
// - SETUP
//   - Lasts CS_SETUP cycles with sclk=0, then enter SHIFT.
// - SHIFT
//   - 16 bits, each 2*CLK_DIV cycles: CLK_DIV cycles sclk=1 (peripheral samples on the rise), then CLK_DIV cycles sclk=0.
//   - copi updates to the next bit in the cycle sclk falls.
//   - A 5-bit bit counter tracks progress. After the 16th high phase, sclk=0; enter HOLD.
// - HOLD
//   - Lasts CLK_DIV cycles with sclk=0 and copi holding bit15.
//   - Then cs=1, done=1 for one cycle, copi=0; enter GAP.
// - cs low duration: exactly CS_SETUP + 33*CLK_DIV cycles (defaults: 136).
// - sclk rising edges per frame: exactly 16.
// - GAP
//   - Lasts CS_GAP cycles with cs=1, then IDLE.
//   - busy=0 and req_ready=1 from the IDLE cycle onward.
// - Back-to-back: with req_valid held high, consecutive frames start every 1 + CS_SETUP + 33*CLK_DIV + CS_GAP cycles.
// - Address/data are sent verbatim: no range check. Addresses > 4 are the peripheral's concern.
// - rst mid-frame (any state):
//   - Next cycle cs=1, sclk=0, state IDLE.
//   - The partial frame is dropped, with no done pulse.
//   - The peripheral discards it because its bit count is not 16 when cs rises.
// - rst has priority over a simultaneous request.
// STRUCTURE
// - Package spi_pkg:
//   - SPI_FRAME_W=16.
//   - Register address constants: ADDR_EN_OUT_7_0=0, ADDR_EN_OUT_15_8=1, ADDR_EN_PWM_7_0=2, ADDR_EN_PWM_15_8=3, ADDR_PWM_DUTY=4.
//   - FSM state enum.
// - One sub-module, spi_clk_div:
//   - Half-period counter ($clog2(CLK_DIV) bits) emitting a one-cycle tick every CLK_DIV cycles while enabled.
//   - Counter clears when disabled.
// - The FSM, shift register and bit counter live in spi_controller.
// TESTING (bench connects copi/sclk/cs to the SPI peripheral plus a protocol monitor)
// - Write addr 0, data 0xA5, wr=1 -> en_reg_out_7_0=0xA5; monitor sees 16 sclk rises, bit stream 1,0,0,0,0,0,0,0,1,0,1,0,0,1,0,1; cs low 136 cycles; one done pulse.
// - req_valid held, addr 4 / 0x80 then addr 2 / 0xFF -> pwm_duty_cycle=0x80, en_reg_pwm_7_0=0xFF; cs high >= 8 cycles between frames; second accept only when req_ready=1.
// - wr=0, addr 1, data 0x3C -> frame bit0=0 on copi; en_reg_out_15_8 stays 0x00; done still pulses.
// - addr 5, data 0x77 -> frame sent verbatim; all peripheral registers unchanged.
// - rst asserted after the 7th sclk rise of addr 3 / 0x55 -> next cycle cs=1, sclk=0, no done; en_reg_pwm_15_8 stays 0; a following addr 3 / 0x55 write succeeds.
// - req_valid pulsed while busy=1 -> ignored: no extra frame, no extra done.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI initiator definitions: frame geometry, peripheral register map
// and the controller state encoding.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_BIT_CNT_W = 5;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Frame bit0 is the write flag and is shifted out first.
    function automatic logic [SPI_FRAME_W-1:0] spi_frame(
        input logic       wr,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {data, addr, wr};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timebase for sclk: one-cycle tick every CLK_DIV clocks while
// enabled, restarting from zero whenever the enable drops.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-write initiator: one 16-bit LSB-first frame per
// accepted request, with programmable cs setup and inter-frame gap.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | cs high, req_ready high, waiting for a request
// ST_SETUP | cs low, sclk low, CS_SETUP cycles before the first rise
// ST_SHIFT | 16 sclk periods, copi advances on each falling edge
// ST_HOLD  | sclk low for CLK_DIV cycles with bit15 still on copi
// ST_GAP   | cs high again, CS_GAP cycles before the next request
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_GAP   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       cs,
    output logic       copi
);

    localparam int TMR_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(CS_GAP - 1);
    localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = SPI_BIT_CNT_W'(SPI_FRAME_W - 1);
    localparam logic [SPI_BIT_CNT_W-1:0] BIT_END = SPI_BIT_CNT_W'(SPI_FRAME_W);

    spi_state_t               state;
    logic [SPI_FRAME_W-1:0]   shreg;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic [TMR_W-1:0]         tmr;
    logic                     div_en;
    logic                     tick;

    assign div_en    = (state == ST_SHIFT) || (state == ST_HOLD);
    assign req_ready = (state == ST_IDLE);

    // shreg[0] is always the bit on the wire, so copi needs no extra mux.
    assign copi = shreg[0];

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            tmr     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        shreg   <= spi_frame(req_wr, req_addr, req_data);
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        tmr     <= SETUP_LOAD;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr == '0) begin
                        sclk  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (sclk) begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + SPI_BIT_CNT_W'(1);
                            // Bit15 stays on copi through the final low phase and HOLD.
                            if (bit_cnt != BIT_LAST) begin
                                shreg <= shreg >> 1;
                            end
                        end else if (bit_cnt == BIT_END) begin
                            state <= ST_HOLD;
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs    <= 1'b1;
                        done  <= 1'b1;
                        shreg <= '0;
                        tmr   <= GAP_LOAD;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: behavioural SPI register peripheral, protocol
// monitor and a frame scoreboard fed at request acceptance.
`timescale 1ns/1ps
module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV      = 4;
    localparam int CS_SETUP     = 4;
    localparam int CS_GAP       = 8;
    localparam int CS_LOW       = CS_SETUP + 33 * CLK_DIV;
    localparam int FRAME_PERIOD = 1 + CS_LOW + CS_GAP;
    localparam int WAIT_LIMIT   = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       cs;
    logic       copi;

    always #5 clk = ~clk;

    spi_controller #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_data (req_data),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .cs       (cs),
        .copi     (copi)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        n_vec++;
        n_fail++;
        $display("FAIL %s: %s", name, detail);
    endtask

    typedef struct {
        logic [15:0] frame;
        bit          abort;
    } exp_t;

    exp_t sb[$];

    // Peripheral: samples copi on sclk rise, commits on cs rise only for a full write frame.
    logic [7:0]  per_regs [0:4];
    logic [15:0] per_sr;
    int          per_cnt = 0;
    logic        per_sclk_q = 1'b0;
    logic        per_cs_q = 1'b1;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!cs && per_cs_q) begin
                per_cnt = 0;
            end
            if (!cs && sclk && !per_sclk_q) begin
                if (per_cnt < 16) per_sr[4'(per_cnt)] = copi;
                per_cnt++;
            end
            if (cs && !per_cs_q) begin
                if (per_cnt == 16 && per_sr[0] && per_sr[7:1] <= 7'd4)
                    per_regs[per_sr[3:1]] = per_sr[15:8];
            end
        end
        per_sclk_q = sclk;
        per_cs_q   = cs;
    end

    // Protocol monitor.
    int          rise_cnt = 0;
    int          cs_low_cnt = 0;
    int          cs_high_cnt = 0;
    int          done_cnt = 0;
    int          frames_seen = 0;
    int          accept_cnt = 0;
    int          cyc = 0;
    logic [15:0] rx_bits;
    bit          first_frame = 1'b1;
    bit          skip_gap = 1'b0;
    logic        m_sclk_q = 1'b0;
    logic        m_cs_q = 1'b1;
    logic        m_copi_q = 1'b0;
    exp_t        mon_e;

    always @(posedge clk) begin
        cyc++;
        if (mon_en && !rst && req_valid && req_ready) accept_cnt++;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (copi !== m_copi_q && sclk)
                flag("copi_stable", $sformatf("copi changed to %0b while sclk high", copi));
            if (!cs && m_cs_q) begin
                if (!first_frame && !skip_gap && cs_high_cnt < CS_GAP)
                    flag("cs_gap_min", $sformatf("cs high %0d cycles, required >= %0d", cs_high_cnt, CS_GAP));
                first_frame = 1'b0;
                skip_gap    = 1'b0;
                cs_low_cnt  = 1;
                rise_cnt    = 0;
                rx_bits     = '0;
            end else if (!cs) begin
                cs_low_cnt++;
            end
            if (sclk && !m_sclk_q) begin
                if (cs) begin
                    flag("sclk_rise_cs_high", "sclk rose while cs high");
                end else begin
                    if (rise_cnt < 16) rx_bits[4'(rise_cnt)] = copi;
                    rise_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                if (!(cs && !m_cs_q)) flag("done_timing", "done not in the cycle cs returned high");
            end
            if (cs && !m_cs_q) begin
                frames_seen++;
                cs_high_cnt = 1;
                if (sb.size() == 0) begin
                    flag("unexpected_frame", "cs frame with no accepted request");
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.abort) begin
                        check("abort_rises", rise_cnt, 7);
                        check("abort_no_done", done, 1'b0);
                        skip_gap = 1'b1;
                    end else begin
                        check("frame_rises", rise_cnt, 16);
                        check("frame_bits", rx_bits, mon_e.frame);
                        check("cs_low_cycles", cs_low_cnt, CS_LOW);
                        check("done_at_cs_rise", done, 1'b1);
                        check("busy_at_end", busy, 1'b1);
                    end
                end
            end else if (cs) begin
                cs_high_cnt++;
            end
        end
        m_sclk_q = sclk;
        m_cs_q   = cs;
        m_copi_q = copi;
    end

    int exp_accepts = 0;
    int last_accept_cyc = 0;

    task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                         input logic [15:0] frame, input bit abort, input bit keep_valid);
        int   t = 0;
        exp_t e;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        while (!req_ready && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            flag("accept_timeout", "req_ready never returned high");
            req_valid = 1'b0;
            return;
        end
        e.frame = frame;
        e.abort = abort;
        sb.push_back(e);
        exp_accepts++;
        last_accept_cyc = cyc;
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_seen < target && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (frames_seen < target) flag("frame_timeout", $sformatf("saw %0d frames, waiting for %0d", frames_seen, target));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!req_ready && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) flag("idle_timeout", "controller never returned to idle");
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
        int          reg_idx;
        logic [7:0]  reg_val;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_regs [0:4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int d0;
        int a0;
        int t;

        vecs[0] = '{1'b1, ADDR_EN_OUT_7_0,  8'hA5, 16'hA501, 0, 8'hA5};
        vecs[1] = '{1'b0, ADDR_EN_OUT_15_8, 8'h3C, 16'h3C02, 1, 8'h00};
        vecs[2] = '{1'b1, 7'd5,             8'h77, 16'h770B, 0, 8'hA5};
        vecs[3] = '{1'b1, ADDR_EN_OUT_15_8, 8'h5A, 16'h5A03, 1, 8'h5A};
        for (int r = 0; r < 5; r++) begin
            per_regs[r] = 8'h00;
            exp_regs[r] = 8'h00;
        end

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_cs", cs, 1'b1);
        check("reset_sclk", sclk, 1'b0);
        check("reset_copi", copi, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", req_ready, 1'b1);
        mon_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            n  = frames_seen;
            d0 = done_cnt;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].frame, 1'b0, 1'b0);
            wait_frames(n + 1);
            exp_regs[vecs[i].reg_idx] = vecs[i].reg_val;
            for (int r = 0; r < 5; r++)
                check($sformatf("vec%0d_reg%0d", i, r), per_regs[r], exp_regs[r]);
            check($sformatf("vec%0d_done_pulses", i), done_cnt - d0, 1);
            wait_idle();
            check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
        end

        // Back-to-back with req_valid held high.
        n = frames_seen;
        issue(1'b1, ADDR_PWM_DUTY, 8'h80, 16'h8009, 1'b0, 1'b1);
        a0 = last_accept_cyc;
        issue(1'b1, ADDR_EN_PWM_7_0, 8'hFF, 16'hFF05, 1'b0, 1'b0);
        check("b2b_period", last_accept_cyc - a0, FRAME_PERIOD);
        wait_frames(n + 2);
        exp_regs[4] = 8'h80;
        exp_regs[2] = 8'hFF;
        check("b2b_pwm_duty", per_regs[4], exp_regs[4]);
        check("b2b_en_pwm_7_0", per_regs[2], exp_regs[2]);
        wait_idle();

        // Reset after the 7th sclk rise drops the frame.
        d0 = done_cnt;
        issue(1'b1, ADDR_EN_PWM_15_8, 8'h55, 16'h5507, 1'b1, 1'b0);
        @(negedge clk);
        t = 0;
        while (rise_cnt < 7 && t < WAIT_LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (rise_cnt < 7) flag("abort_wait", "7th sclk rise never seen");
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_reg3", per_regs[3], 8'h00);
        check("abort_done_count", done_cnt - d0, 0);
        n = frames_seen;
        issue(1'b1, ADDR_EN_PWM_15_8, 8'h55, 16'h5507, 1'b0, 1'b0);
        wait_frames(n + 1);
        exp_regs[3] = 8'h55;
        check("retry_reg3", per_regs[3], exp_regs[3]);
        wait_idle();

        // Requests pulsed while busy, in SHIFT and in GAP, are ignored.
        n  = frames_seen;
        d0 = done_cnt;
        issue(1'b1, ADDR_EN_OUT_7_0, 8'h3E, 16'h3E01, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        req_wr = 1'b1; req_addr = ADDR_EN_PWM_7_0; req_data = 8'h11; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_frames(n + 1);
        check("gap_busy", busy, 1'b1);
        req_wr = 1'b1; req_addr = ADDR_EN_PWM_7_0; req_data = 8'h22; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);
        exp_regs[0] = 8'h3E;
        check("busy_pulse_frames", frames_seen - n, 1);
        check("busy_pulse_done", done_cnt - d0, 1);
        check("busy_pulse_reg0", per_regs[0], exp_regs[0]);
        check("busy_pulse_reg2", per_regs[2], exp_regs[2]);
        check("accept_count", accept_cnt, exp_accepts);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
